// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register and EX-operand stage of the five-stage RV32I core.
// This stage captures the operands and control bits from decode. It resolves
// RAW hazards by forwarding from the MEM and WB stages. It then presents the
// final ALU operands, the store data and the control bits that travel on to
// EX/MEM. It also detects load-use hazards and requests a one-cycle bubble.
//
// Ports
//   clk, rst_n            : rising-edge clock, asynchronous active-low reset
//   stall                 : hold the stage (downstream back-pressure)
//   flush                 : capture a bubble (taken branch/jump in EX)
//   id_*                  : decoded instruction fields and control from ID
//   mem_regwrite/rd/aluresult : MEM-stage writeback info, forwarding source
//   wb_regwrite/rd/result : WB-stage writeback info, forwarding source
//   ex_alu_a, ex_alu_b    : forwarded and muxed ALU operands
//   ex_alucontrol         : 3-bit ALU operation, passed through unchanged
//   ex_writedata          : forwarded rs2 value, used as store data
//   ex_pc, ex_imm, ex_rd  : fields carried on to EX/MEM
//   ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump :
//                           carried control bits
//   load_use_stall        : combinational request to freeze PC and IF/ID
// ---------------------------------------------------------------------------
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rd1,
  input  logic [31:0] id_rd2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [2:0]  id_alucontrol,
  input  logic        id_alusrca,
  input  logic        id_alusrcb,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        id_branch,
  input  logic        id_jump,
  input  logic        mem_regwrite,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_aluresult,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic [31:0] ex_alu_a,
  output logic [31:0] ex_alu_b,
  output logic [2:0]  ex_alucontrol,
  output logic [31:0] ex_writedata,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic        ex_valid,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        load_use_stall
);

  // An all-zero value of this struct is a bubble.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alucontrol;
    logic        alusrca;
    logic        alusrcb;
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        jump;
  } id_ex_t;

  id_ex_t stage_reg;
  id_ex_t stage_next;
  id_ex_t id_fields;

  logic [31:0] fwd_a;
  logic [31:0] fwd_b;

  always_comb begin
    id_fields.pc         = id_pc;
    id_fields.rd1        = id_rd1;
    id_fields.rd2        = id_rd2;
    id_fields.imm        = id_imm;
    id_fields.rs1        = id_rs1;
    id_fields.rs2        = id_rs2;
    id_fields.rd         = id_rd;
    id_fields.alucontrol = id_alucontrol;
    id_fields.alusrca    = id_alusrca;
    id_fields.alusrcb    = id_alusrcb;
    id_fields.valid      = id_valid;
    id_fields.regwrite   = id_regwrite;
    id_fields.memread    = id_memread;
    id_fields.memwrite   = id_memwrite;
    id_fields.branch     = id_branch;
    id_fields.jump       = id_jump;
  end

  // Both source indices are always compared, even when the decoded
  // instruction does not use rs2. This can add a harmless extra bubble.
  // It never misses a real hazard.
  assign load_use_stall = stage_reg.valid & stage_reg.memread &
                          (stage_reg.rd != 5'd0) & id_valid &
                          ((stage_reg.rd == id_rs1) | (stage_reg.rd == id_rs2));

  // The update order is flush, then stall, then load-use, then normal load.
  // A stall that arrives together with a load-use hazard holds the load in
  // EX. The hazard request therefore stays high until the stall releases.
  always_comb begin
    stage_next = stage_reg;
    if (flush) begin
      stage_next = '0;
    end else if (stall) begin
      stage_next = stage_reg;
    end else if (load_use_stall) begin
      stage_next = '0;
    end else begin
      stage_next = id_fields;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  // Forwarding takes the youngest producer first, so MEM wins over WB.
  // Index 0 never forwards. x0 reads come from the register file as 0.
  always_comb begin
    fwd_a = stage_reg.rd1;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == stage_reg.rs1)) begin
      fwd_a = mem_aluresult;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == stage_reg.rs1)) begin
      fwd_a = wb_result;
    end
  end

  always_comb begin
    fwd_b = stage_reg.rd2;
    if (mem_regwrite && (mem_rd != 5'd0) && (mem_rd == stage_reg.rs2)) begin
      fwd_b = mem_aluresult;
    end else if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == stage_reg.rs2)) begin
      fwd_b = wb_result;
    end
  end

  assign ex_alu_a      = stage_reg.alusrca ? stage_reg.pc  : fwd_a;
  assign ex_alu_b      = stage_reg.alusrcb ? stage_reg.imm : fwd_b;
  assign ex_writedata  = fwd_b;
  assign ex_alucontrol = stage_reg.alucontrol;
  assign ex_pc         = stage_reg.pc;
  assign ex_imm        = stage_reg.imm;
  assign ex_rd         = stage_reg.rd;
  assign ex_valid      = stage_reg.valid;
  assign ex_regwrite   = stage_reg.regwrite;
  assign ex_memread    = stage_reg.memread;
  assign ex_memwrite   = stage_reg.memwrite;
  assign ex_branch     = stage_reg.branch;
  assign ex_jump       = stage_reg.jump;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//
// Directed testbench for id_ex_stage. It has one task per scenario, and each
// task makes its own checks against hand-computed values.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
  localparam logic [2:0] ALU_CTRL_SUB = 3'b110;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic [31:0] id_imm;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [2:0]  id_alucontrol;
  logic        id_alusrca;
  logic        id_alusrcb;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        id_branch;
  logic        id_jump;
  logic        mem_regwrite;
  logic [4:0]  mem_rd;
  logic [31:0] mem_aluresult;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic [31:0] ex_alu_a;
  logic [31:0] ex_alu_b;
  logic [2:0]  ex_alucontrol;
  logic [31:0] ex_writedata;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_valid;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_branch;
  logic        ex_jump;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alucontrol(id_alucontrol), .id_alusrca(id_alusrca),
    .id_alusrcb(id_alusrcb), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_branch(id_branch), .id_jump(id_jump),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_aluresult(mem_aluresult),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alucontrol(ex_alucontrol),
    .ex_writedata(ex_writedata), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge. Outputs are then sampled 1 ns after that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [31:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [2:0] alu, input logic asa, input logic asb,
                        input logic rw, input logic mr, input logic mw,
                        input logic br, input logic jp);
    id_valid = v;    id_pc = pc;      id_rd1 = rd1;    id_rd2 = rd2;
    id_imm = imm;    id_rs1 = rs1;    id_rs2 = rs2;    id_rd = rd;
    id_alucontrol = alu; id_alusrca = asa; id_alusrcb = asb;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw;
    id_branch = br;  id_jump = jp;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; flush = 1'b0;
    set_id(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 3'd0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mem_regwrite = 1'b0; mem_rd = 5'd0; mem_aluresult = 32'h0;
    wb_regwrite = 1'b0;  wb_rd = 5'd0;  wb_result = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_alu_a !== 32'h0 || ex_alu_b !== 32'h0 || ex_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_initial: valid=%b a=%h b=%h pc=%h expected all 0",
               ex_valid, ex_alu_a, ex_alu_b, ex_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b1, 32'h20, 32'h55, 32'h66, 32'h4, 5'd1, 5'd2, 5'd9, ALU_CTRL_SUB,
           1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_alu_a !== 32'h55 || ex_pc !== 32'h20) begin
      errors++;
      $display("FAIL reset_preload: valid=%b a=%h pc=%h expected 1 00000055 00000020",
               ex_valid, ex_alu_a, ex_pc);
    end
    // Assert reset between edges. The outputs must clear without waiting for a clock.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 ||
        ex_alu_a !== 32'h0 || ex_alu_b !== 32'h0 || ex_pc !== 32'h0 ||
        ex_rd !== 5'd0 || ex_alucontrol !== 3'd0 || load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: valid=%b rw=%b mr=%b a=%h b=%h pc=%h rd=%0d alu=%0d lus=%b expected all 0",
               ex_valid, ex_regwrite, ex_memread, ex_alu_a, ex_alu_b, ex_pc, ex_rd,
               ex_alucontrol, load_use_stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_id(1'b1, 32'h24, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, ALU_CTRL_ADD,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ex_alu_a !== 32'd5 || ex_alu_b !== 32'd7 || ex_alucontrol !== ALU_CTRL_ADD ||
        ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_add: a=%0d b=%0d alu=%0d valid=%b expected 5 7 %0d 1",
               ex_alu_a, ex_alu_b, ex_alucontrol, ex_valid, ALU_CTRL_ADD);
    end
    $display("test_reset: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    set_id(1'b1, 32'h30, 32'hAA, 32'hBB, 32'h0, 5'd3, 5'd4, 5'd8, ALU_CTRL_ADD,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    mem_regwrite = 1'b1; mem_rd = 5'd3; mem_aluresult = 32'h11;
    wb_regwrite = 1'b1;  wb_rd = 5'd3;  wb_result = 32'h22;
    #1;
    checks++;
    if (ex_alu_a !== 32'h11) begin
      errors++;
      $display("FAIL fwd_mem_over_wb: ex_alu_a=%h expected 00000011", ex_alu_a);
    end
    mem_regwrite = 1'b0;
    #1;
    checks++;
    if (ex_alu_a !== 32'h22) begin
      errors++;
      $display("FAIL fwd_wb: ex_alu_a=%h expected 00000022", ex_alu_a);
    end
    mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
    #1;
    checks++;
    if (ex_alu_a !== 32'hAA) begin
      errors++;
      $display("FAIL fwd_x0_none: ex_alu_a=%h expected 000000aa", ex_alu_a);
    end
    mem_regwrite = 1'b0; wb_rd = 5'd4;
    #1;
    checks++;
    if (ex_alu_b !== 32'h22 || ex_writedata !== 32'h22 || ex_alu_a !== 32'hAA) begin
      errors++;
      $display("FAIL fwd_b_wb: b=%h wd=%h a=%h expected 00000022 00000022 000000aa",
               ex_alu_b, ex_writedata, ex_alu_a);
    end
    $display("test_forward_priority: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_load_use();
    idle_inputs();
    // A load to x0 must never request a stall.
    set_id(1'b1, 32'h40, 32'h100, 32'h0, 32'h0, 5'd1, 5'd0, 5'd0, ALU_CTRL_ADD,
           1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 32'h44, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd6, ALU_CTRL_ADD,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL lus_rd0: load_use_stall=%b expected 0", load_use_stall);
    end
    // lw x5, 4(x1)
    set_id(1'b1, 32'h48, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd0, 5'd5, ALU_CTRL_ADD,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    // add x7, x6, x5 now in decode
    set_id(1'b1, 32'h4C, 32'd3, 32'h999, 32'h0, 5'd6, 5'd5, 5'd7, ALU_CTRL_ADD,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++;
    if (load_use_stall !== 1'b1) begin
      errors++;
      $display("FAIL lus_detect: load_use_stall=%b expected 1", load_use_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 ||
        ex_pc !== 32'h0 || load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL lus_bubble: valid=%b rw=%b mr=%b pc=%h lus=%b expected 0 0 0 0 0",
               ex_valid, ex_regwrite, ex_memread, ex_pc, load_use_stall);
    end
    tick();
    // The load is now in WB and the bubble is in MEM.
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_result = 32'hCAFE;
    #1;
    checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || ex_alu_b !== 32'hCAFE ||
        ex_alu_a !== 32'd3 || load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL lus_release: valid=%b rd=%0d b=%h a=%h lus=%b expected 1 7 0000cafe 00000003 0",
               ex_valid, ex_rd, ex_alu_b, ex_alu_a, load_use_stall);
    end
    // stall together with a load-use hazard must hold the load, not insert a bubble.
    idle_inputs();
    set_id(1'b1, 32'h50, 32'h1000, 32'h0, 32'h8, 5'd1, 5'd0, 5'd5, ALU_CTRL_ADD,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 32'h54, 32'h0, 32'h0, 32'h0, 5'd5, 5'd2, 5'd9, ALU_CTRL_ADD,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    stall = 1'b1;
    tick();
    checks++;
    if (ex_memread !== 1'b1 || ex_pc !== 32'h50 || load_use_stall !== 1'b1) begin
      errors++;
      $display("FAIL lus_with_stall: mr=%b pc=%h lus=%b expected 1 00000050 1",
               ex_memread, ex_pc, load_use_stall);
    end
    stall = 1'b0;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_memread !== 1'b0) begin
      errors++;
      $display("FAIL lus_stall_bubble: valid=%b mr=%b expected 0 0", ex_valid, ex_memread);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h54) begin
      errors++;
      $display("FAIL lus_stall_release: valid=%b pc=%h expected 1 00000054", ex_valid, ex_pc);
    end
    $display("test_load_use: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_flush_priority();
    idle_inputs();
    set_id(1'b1, 32'h70, 32'h1, 32'h2, 32'h0, 5'd1, 5'd2, 5'd4, ALU_CTRL_ADD,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 32'h80, 32'h3, 32'h4, 32'h10, 5'd1, 5'd2, 5'd6, ALU_CTRL_SUB,
           1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    flush = 1'b1; stall = 1'b1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0 || ex_memread !== 1'b0 ||
        ex_memwrite !== 1'b0 || ex_branch !== 1'b0 || ex_jump !== 1'b0 ||
        ex_pc !== 32'h0 || ex_rd !== 5'd0) begin
      errors++;
      $display("FAIL flush_over_stall: v=%b rw=%b mr=%b mw=%b br=%b jp=%b pc=%h rd=%0d expected all 0",
               ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_branch, ex_jump, ex_pc, ex_rd);
    end
    flush = 1'b0; stall = 1'b0;
    $display("test_flush_priority: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_stall_hold();
    idle_inputs();
    set_id(1'b1, 32'h40, 32'h10, 32'h20, 32'h0, 5'd8, 5'd9, 5'd10, ALU_CTRL_SUB,
           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 32'h100 + 32'(i * 4), 32'h500 + 32'(i), 32'h600, 32'h7, 5'd11, 5'd12,
             5'd13, ALU_CTRL_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      mem_regwrite = 1'b1; mem_rd = 5'd8; mem_aluresult = 32'h100 + 32'(i);
      tick();
      checks++;
      if (ex_pc !== 32'h40 || ex_rd !== 5'd10 || ex_alucontrol !== ALU_CTRL_SUB ||
          ex_valid !== 1'b1 || ex_regwrite !== 1'b1 || ex_memwrite !== 1'b0 ||
          ex_alu_b !== 32'h20 || ex_alu_a !== 32'h100 + 32'(i)) begin
        errors++;
        $display("FAIL stall_hold_%0d: pc=%h rd=%0d alu=%0d v=%b rw=%b mw=%b a=%h b=%h expected 00000040 10 %0d 1 1 0 %h 00000020",
                 i, ex_pc, ex_rd, ex_alucontrol, ex_valid, ex_regwrite, ex_memwrite,
                 ex_alu_a, ex_alu_b, ALU_CTRL_SUB, 32'h100 + 32'(i));
      end
    end
    stall = 1'b0;
    $display("test_stall_hold: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_imm_pc_mux();
    idle_inputs();
    set_id(1'b1, 32'h100, 32'h1, 32'h2, 32'hFFFFF000, 5'd11, 5'd12, 5'd14, ALU_CTRL_ADD,
           1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    checks++;
    if (ex_alu_a !== 32'h100 || ex_alu_b !== 32'hFFFFF000 || ex_writedata !== 32'h2 ||
        ex_imm !== 32'hFFFFF000) begin
      errors++;
      $display("FAIL mux_pc_imm: a=%h b=%h wd=%h imm=%h expected 00000100 fffff000 00000002 fffff000",
               ex_alu_a, ex_alu_b, ex_writedata, ex_imm);
    end
    wb_regwrite = 1'b1; wb_rd = 5'd12; wb_result = 32'h77;
    mem_regwrite = 1'b1; mem_rd = 5'd11; mem_aluresult = 32'h88;
    #1;
    checks++;
    if (ex_writedata !== 32'h77 || ex_alu_b !== 32'hFFFFF000 || ex_alu_a !== 32'h100) begin
      errors++;
      $display("FAIL mux_wd_fwd: wd=%h b=%h a=%h expected 00000077 fffff000 00000100",
               ex_writedata, ex_alu_b, ex_alu_a);
    end
    $display("test_imm_pc_mux: done, checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_forward_priority();
    test_load_use();
    test_flush_priority();
    test_stall_hold();
    test_imm_pc_mux();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
